// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops narrow FIFO entries and packs PACK of them into one wide word,
// flushing a partial word on request or after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
    input  logic                       rempty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rinc,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_valid,
    input  logic                       m_ready
);
    localparam int CW = $clog2(PACK + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {EMPTY, FILL, SEND} state_t;

    state_t                           state_q, state_d;
    logic [PACK-1:0][DATA_WIDTH-1:0]  data_q, data_d;
    logic [PACK-1:0]                  keep_q, keep_d;
    logic [CW-1:0]                    count_q, count_d, count_inc;
    logic [IW-1:0]                    idle_q, idle_d;
    logic                             go;

    function automatic logic [PACK-1:0] lanes(input logic [CW-1:0] n);
        for (int i = 0; i < PACK; i++) lanes[i] = CW'(i) < n;
    endfunction

    assign rinc      = rrst_n & ~rempty & (state_q != SEND);
    assign count_inc = count_q + CW'(1);
    assign go        = flush || count_inc == CW'(PACK);
    assign m_valid   = state_q == SEND;
    assign m_data    = data_q;
    assign m_keep    = keep_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        count_d = count_q;
        idle_d  = idle_q;
        if (state_q == SEND) begin
            // lanes are zeroed on exit so a later partial word carries zero padding
            if (m_ready) begin
                state_d = EMPTY;
                data_d  = '0;
                keep_d  = '0;
                count_d = '0;
                idle_d  = '0;
            end
        end else if (rinc) begin
            for (int i = 0; i < PACK; i++) if (count_q == CW'(i)) data_d[i] = rdata;
            count_d = count_inc;
            idle_d  = '0;
            state_d = go ? SEND : FILL;
            keep_d  = go ? lanes(count_inc) : '0;
        end else if (state_q == FILL) begin
            idle_d = idle_q + IW'(1);
            if (flush || idle_d == IW'(TIMEOUT)) begin
                state_d = SEND;
                keep_d  = lanes(count_q);
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            count_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            count_q <= count_d;
            idle_q  <= idle_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed vector table plus hand-written sequences for timeout,
// flush-with-pop and reset mid-fill.
module tb_fifo_rd_packer;
    logic        rclk = 1'b0;
    logic        rrst_n, rempty, rinc, flush, m_valid, m_ready;
    logic [7:0]  rdata;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    int          checks = 0;
    int          errors = 0;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(15)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        bit        rst_n, rempty;
        bit [7:0]  rdata;
        bit        flush, ready, e_rinc, e_valid;
        bit [31:0] e_data;
        bit [3:0]  e_keep;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(bit rst_n, bit re, bit [7:0] d, bit fl, bit rdy,
                               bit er, bit ev, bit [31:0] ed, bit [3:0] ek);
        v = '{rst_n, re, d, fl, rdy, er, ev, ed, ek};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive inputs, then advance through one rising edge and settle
    task automatic cyc(input bit re, input bit [7:0] d, input bit fl, input bit rdy);
        rempty = re; rdata = d; flush = fl; m_ready = rdy;
        #1;
        @(posedge rclk); #1;
    endtask

    initial begin
        rrst_n = 1'b0; rempty = 1'b1; rdata = '0; flush = 1'b0; m_ready = 1'b0;
        @(posedge rclk); #1;

        vt.push_back(v(0, 0, 8'h11, 0, 1, 0, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h44, 0, 1, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h55, 0, 1, 0, 1, 32'h44332211, 4'hF));
        vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0));
        for (int i = 1; i <= 4; i++) vt.push_back(v(1, 0, 8'(i), 0, 0, 1, 0, 32'h0, 4'h0));
        for (int i = 0; i < 10; i++) vt.push_back(v(1, 0, 8'h55, 0, 0, 0, 1, 32'h04030201, 4'hF));
        vt.push_back(v(1, 0, 8'h55, 0, 1, 0, 1, 32'h04030201, 4'hF));
        vt.push_back(v(1, 0, 8'h55, 0, 1, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 1, 8'h00, 1, 0, 0, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 1, 32'h00000055, 4'h1));
        vt.push_back(v(1, 1, 8'h00, 0, 1, 0, 1, 32'h00000055, 4'h1));
        vt.push_back(v(1, 1, 8'h00, 1, 0, 0, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 0, 8'h9A, 1, 0, 1, 0, 32'h0, 4'h0));
        vt.push_back(v(1, 1, 8'h00, 0, 1, 0, 1, 32'h0000009A, 4'h1));
        vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0));

        foreach (vt[i]) begin
            rrst_n = vt[i].rst_n; rempty = vt[i].rempty; rdata = vt[i].rdata;
            flush = vt[i].flush; m_ready = vt[i].ready;
            #1;
            chk($sformatf("v%0d rinc", i), 32'(rinc), 32'(vt[i].e_rinc));
            chk($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d m_keep", i), 32'(m_keep), 32'(vt[i].e_keep));
            if (vt[i].e_valid) chk($sformatf("v%0d m_data", i), m_data, vt[i].e_data);
            @(posedge rclk); #1;
        end

        // timeout: two entries then 15 idle cycles
        cyc(0, 8'hAA, 0, 0);
        cyc(0, 8'hBB, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            cyc(1, 8'h00, 0, 0);
            chk($sformatf("timeout idle%0d m_valid", k), 32'(m_valid), 32'd0);
        end
        cyc(1, 8'h00, 0, 0);
        chk("timeout m_valid", 32'(m_valid), 32'd1);
        chk("timeout m_data", m_data, 32'h0000BBAA);
        chk("timeout m_keep", 32'(m_keep), 32'h3);
        cyc(1, 8'h00, 0, 1);
        chk("timeout drain m_valid", 32'(m_valid), 32'd0);

        // flush together with a pop at count=2
        cyc(0, 8'h01, 0, 0);
        cyc(0, 8'h02, 0, 0);
        rempty = 1'b0; rdata = 8'hCC; flush = 1'b1;
        #1;
        chk("flushpop rinc", 32'(rinc), 32'd1);
        @(posedge rclk); #1;
        flush = 1'b0;
        #1;
        chk("flushpop m_valid", 32'(m_valid), 32'd1);
        chk("flushpop m_keep", 32'(m_keep), 32'h7);
        chk("flushpop m_data", m_data, 32'h00CC0201);
        chk("flushpop no pop in SEND", 32'(rinc), 32'd0);
        cyc(0, 8'hCC, 0, 1);
        chk("flushpop drain m_valid", 32'(m_valid), 32'd0);

        // reset with three lanes filled
        cyc(0, 8'hD1, 0, 0);
        cyc(0, 8'hD2, 0, 0);
        cyc(0, 8'hD3, 0, 0);
        rrst_n = 1'b0; rdata = 8'hD4;
        #1;
        chk("rst rinc", 32'(rinc), 32'd0);
        @(posedge rclk); #1;
        rrst_n = 1'b1;
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_keep", 32'(m_keep), 32'd0);
        chk("rst m_data", m_data, 32'd0);
        for (int i = 1; i <= 4; i++) cyc(0, 8'(8'h70 + i), 0, 0);
        chk("rst refill m_valid", 32'(m_valid), 32'd1);
        chk("rst refill m_data", m_data, 32'h74737271);
        chk("rst refill m_keep", 32'(m_keep), 32'hF);
        cyc(1, 8'h00, 0, 1);
        chk("rst refill drain m_valid", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one FIFO entry.
REQ-002 SHALL have parameter PACK, default 4, entries per output word, legal range 2..8.
REQ-003 SHALL have parameter TIMEOUT, default 15, idle cycles in FILL before a partial flush, legal range 1..255.
REQ-004 SHALL have port rclk  input  1  sole clock, rising edge; one clock, no other clock domain.
REQ-005 SHALL have port rrst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rempty  input  1  FIFO read-side empty flag.
REQ-007 SHALL have port rdata  input  DATA_WIDTH  FIFO head entry, valid whenever rempty=0.
REQ-008 SHALL have port rinc  output  1  FIFO pop strobe, one entry per cycle high.
REQ-009 SHALL have port flush  input  1  request to emit a partial word now.
REQ-010 SHALL have port m_data  output  DATA_WIDTH*PACK  packed word, lane 0 in LSBs.
REQ-011 SHALL have port m_keep  output  PACK  per-lane valid mask, bit i = lane i.
REQ-012 SHALL have port m_valid  output  1  packed word available.
REQ-013 SHALL have port m_ready  input  1  downstream accepts word when high with m_valid.

Function
REQ-014 SHALL implement states EMPTY (count=0), FILL (0<count<PACK), SEND (m_valid=1).
REQ-015 SHALL drive rinc = rrst_n & ~rempty & (state != SEND), combinational.
REQ-016 SHALL, on each rinc cycle, store rdata into lane[count] and increment count by 1.
REQ-017 SHALL enter SEND the cycle after count reaches PACK, with m_keep all ones.
REQ-018 SHALL, in FILL, increment an idle counter each cycle rinc=0 and clear it on any rinc.
REQ-019 SHALL enter SEND from FILL when idle counter equals TIMEOUT or flush=1, with m_keep = (1<<count)-1.
REQ-020 SHALL, when flush=1 and rinc=1 in the same FILL/EMPTY cycle, capture the entry first, then enter SEND with m_keep covering count+1 lanes.
REQ-021 SHALL ignore flush in EMPTY when rinc=0, and in SEND.
REQ-022 SHALL drive unused lanes of m_data to zero whenever m_valid=1.
REQ-023 SHALL hold m_data, m_keep, m_valid stable in SEND until m_ready=1.
REQ-024 SHALL, on m_valid & m_ready, clear count and idle counter, deassert m_valid next cycle, go to EMPTY.
REQ-025 SHALL never pop in SEND; sustained throughput is one word per PACK+1 cycles.
REQ-026 SHALL size count to hold 0..PACK and idle counter to hold 0..TIMEOUT without wrap.

Reset
REQ-027 SHALL, with rrst_n=0 at a rclk edge, set state EMPTY, count 0, idle counter 0, m_valid 0, m_data 0, m_keep 0.
REQ-028 SHALL hold rinc=0 while rrst_n=0, including mid-FILL or mid-SEND; partial data is discarded.

Verification
REQ-029 SHALL cover full pack: FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> rinc high 4 cycles, then m_data=0x44332211, m_keep=4'b1111, m_valid 1 cycle.
REQ-030 SHALL cover timeout: 2 entries 0xAA,0xBB then rempty=1 -> after 15 idle cycles m_data=0x0000BBAA, m_keep=4'b0011.
REQ-031 SHALL cover backpressure: full word with m_ready=0 for 10 cycles -> m_valid held, m_data unchanged, rinc=0 throughout though rempty=0.
REQ-032 SHALL cover flush with pop: count=2, flush=1 and rinc=1 same cycle with rdata=0xCC -> m_keep=4'b0111, lane 2=0xCC.
REQ-033 SHALL cover flush in EMPTY: flush=1, rempty=1 -> m_valid stays 0, no state change.
REQ-034 SHALL cover reset mid-FILL: count=3, rrst_n=0 one cycle -> m_valid=0, m_keep=0, next word starts at lane 0.
